// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg
// Shared types and helpers for the multi-channel clock-enable generator.
//   DIV_WIDTH_DEFAULT : default divisor/counter width
//   div_t             : divisor type at the default width
//   sanitize_div()    : maps a divisor of 0 to 1
//   half_ceil()       : ceil(D/2), the high time of the square wave
// Helpers work on 32-bit values so any DIV_WIDTH up to 32 can use them.
package clkdiv_pkg;

    localparam int DIV_WIDTH_DEFAULT = 16;

    typedef logic [DIV_WIDTH_DEFAULT-1:0] div_t;

    function automatic logic [31:0] sanitize_div(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

    function automatic logic [31:0] half_ceil(input logic [31:0] d);
        return (d >> 1) + {31'd0, d[0]};
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// clkdiv_chan
// One divider channel: shadow divisor, active divisor, counter and the
// registered tick/wave outputs.
//   clk_in  : system clock (rising edge)
//   rst_n   : asynchronous active-low reset
//   en      : run enable (level)
//   clr     : synchronous phase restart
//   wr      : pre-decoded divisor write strobe for this channel
//   wr_div  : divisor value to write (0 is taken as 1)
//   tick    : one-cycle strobe per period
//   wave    : square wave, high ceil(D/2) cycles, low floor(D/2)
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int DIV_WIDTH   = DIV_WIDTH_DEFAULT,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 wr,
    input  logic [DIV_WIDTH-1:0] wr_div,
    output logic                 tick,
    output logic                 wave
);

    logic [DIV_WIDTH-1:0] shadow;
    logic [DIV_WIDTH-1:0] active;
    logic [DIV_WIDTH-1:0] cnt;

    logic [DIV_WIDTH-1:0] wr_val;
    logic [DIV_WIDTH-1:0] s_next;
    logic [DIV_WIDTH-1:0] a_next;
    logic [DIV_WIDTH-1:0] a_last;
    logic [DIV_WIDTH-1:0] cnt_next;
    logic [DIV_WIDTH-1:0] hc;
    logic                 run;
    logic                 wrap;
    logic                 boundary;
    logic                 tick_next;
    logic                 wave_next;

    always_comb begin
        wr_val = DIV_WIDTH'(sanitize_div(32'(wr_div)));
        // A write landing on a boundary edge is forwarded straight into A.
        s_next = wr ? wr_val : shadow;
        // active is never 0 (sanitized on write, DEFAULT_DIV >= 1)
        a_last = active - DIV_WIDTH'(1);
        run    = en & ~clr;
        // >= rather than == so an out-of-range counter wraps on its own
        wrap     = (cnt >= a_last);
        boundary = ~run | wrap;
        a_next   = boundary ? s_next : active;

        cnt_next = '0;
        if (run && !wrap) begin
            cnt_next = cnt + DIV_WIDTH'(1);
        end

        hc        = DIV_WIDTH'(half_ceil(32'(a_next)));
        tick_next = run & wrap;
        wave_next = run & (cnt_next < hc);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= DIV_WIDTH'(DEFAULT_DIV);
            active <= DIV_WIDTH'(DEFAULT_DIV);
            cnt    <= '0;
            tick   <= 1'b0;
            wave   <= 1'b0;
        end else begin
            shadow <= s_next;
            active <= a_next;
            cnt    <= cnt_next;
            tick   <= tick_next;
            wave   <= wave_next;
        end
    end

endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi
// Multi-channel programmable clock-enable generator. Outputs are enables
// and levels in the clk_in domain, not clocks.
//   clk_in   : system clock (rising edge)
//   rst_n    : asynchronous active-low reset
//   en       : per-channel run enable
//   sync_clr : restarts every channel on the same edge
//   wr_en    : divisor write strobe
//   wr_ch    : channel index for the write (>= NUM_CH ignored)
//   wr_div   : new divisor (0 is taken as 1)
//   tick     : per-channel one-cycle strobe
//   wave     : per-channel square wave
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int  NUM_CH      = 4,
    parameter int  DIV_WIDTH   = DIV_WIDTH_DEFAULT,
    parameter int  DEFAULT_DIV = 2,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    en,
    input  logic                 sync_clr,
    input  logic                 wr_en,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [DIV_WIDTH-1:0] wr_div,
    output logic [NUM_CH-1:0]    tick,
    output logic [NUM_CH-1:0]    wave
);

    logic [31:0] wr_ch_ext;
    logic        wr_hit;

    // Non-power-of-two channel counts leave unused wr_ch codes; drop them.
    assign wr_ch_ext = 32'(wr_ch);
    assign wr_hit    = wr_en && (wr_ch_ext < 32'(NUM_CH));

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic wr_sel;

        assign wr_sel = wr_hit && (wr_ch_ext == 32'(g));

        clkdiv_chan #(
            .DIV_WIDTH   (DIV_WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_in (clk_in),
            .rst_n  (rst_n),
            .en     (en[g]),
            .clr    (sync_clr),
            .wr     (wr_sel),
            .wr_div (wr_div),
            .tick   (tick[g]),
            .wave   (wave[g])
        );
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
module tb_clkdiv_multi;

    logic        clk_in;
    logic        rst_n;
    logic [3:0]  en;
    logic        sync_clr;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [15:0] wr_div;
    logic [3:0]  tick;
    logic [3:0]  wave;

    logic [2:0]  en3;
    logic        sync_clr3;
    logic        wr_en3;
    logic [1:0]  wr_ch3;
    logic [15:0] wr_div3;
    logic [2:0]  tick3;
    logic [2:0]  wave3;

    int n_checks;
    int n_fail;

    clkdiv_multi #(.NUM_CH(4), .DIV_WIDTH(16), .DEFAULT_DIV(2)) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en       (en),
        .sync_clr (sync_clr),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_div   (wr_div),
        .tick     (tick),
        .wave     (wave)
    );

    clkdiv_multi #(.NUM_CH(3), .DIV_WIDTH(16), .DEFAULT_DIV(2)) dut3 (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en       (en3),
        .sync_clr (sync_clr3),
        .wr_en    (wr_en3),
        .wr_ch    (wr_ch3),
        .wr_div   (wr_div3),
        .tick     (tick3),
        .wave     (wave3)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    typedef struct {
        logic [3:0]  en;
        logic        wr_en;
        logic [1:0]  wr_ch;
        logic [15:0] wr_div;
        logic [3:0]  exp_tick;
        logic [3:0]  exp_wave;
    } vec_t;

    vec_t vec[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        en        = '0;
        sync_clr  = 1'b0;
        wr_en     = 1'b0;
        en3       = '0;
        wr_en3    = 1'b0;
        rst_n     = 1'b0;
        step();
        rst_n     = 1'b1;
    endtask

    task automatic write(input logic [1:0] ch, input logic [15:0] d);
        wr_en  = 1'b1;
        wr_ch  = ch;
        wr_div = d;
        step();
        wr_en  = 1'b0;
    endtask

    initial begin
        logic [0:26] w_reload;
        logic [0:7]  w_dis;
        logic [3:0]  et;
        logic [3:0]  ew;

        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        en        = 4'hF;
        sync_clr  = 1'b0;
        wr_en     = 1'b0;
        wr_ch     = '0;
        wr_div    = '0;
        en3       = '0;
        sync_clr3 = 1'b0;
        wr_en3    = 1'b0;
        wr_ch3    = '0;
        wr_div3   = '0;

        // reset defaults (D=2 everywhere), then divisor 5 on ch1
        vec[0]  = '{4'hF, 1'b0, 2'd0, 16'd0, 4'h0, 4'h0};
        vec[1]  = '{4'hF, 1'b0, 2'd0, 16'd0, 4'hF, 4'hF};
        vec[2]  = '{4'hF, 1'b0, 2'd0, 16'd0, 4'h0, 4'h0};
        vec[3]  = '{4'hF, 1'b0, 2'd0, 16'd0, 4'hF, 4'hF};
        vec[4]  = '{4'h0, 1'b1, 2'd1, 16'd5, 4'h0, 4'h0};
        vec[5]  = '{4'h2, 1'b0, 2'd0, 16'd0, 4'h0, 4'h2};
        vec[6]  = '{4'h2, 1'b0, 2'd0, 16'd0, 4'h0, 4'h2};
        vec[7]  = '{4'h2, 1'b0, 2'd0, 16'd0, 4'h0, 4'h0};
        vec[8]  = '{4'h2, 1'b0, 2'd0, 16'd0, 4'h0, 4'h0};
        vec[9]  = '{4'h2, 1'b0, 2'd0, 16'd0, 4'h2, 4'h2};
        vec[10] = '{4'h2, 1'b0, 2'd0, 16'd0, 4'h0, 4'h2};
        vec[11] = '{4'h2, 1'b0, 2'd0, 16'd0, 4'h0, 4'h2};
        vec[12] = '{4'h2, 1'b0, 2'd0, 16'd0, 4'h0, 4'h0};
        vec[13] = '{4'h2, 1'b0, 2'd0, 16'd0, 4'h0, 4'h0};
        vec[14] = '{4'h2, 1'b0, 2'd0, 16'd0, 4'h2, 4'h2};
        vec[15] = '{4'h2, 1'b1, 2'd1, 16'd0, 4'h0, 4'h2};
        vec[16] = '{4'h2, 1'b0, 2'd0, 16'd0, 4'h0, 4'h2};
        vec[17] = '{4'h2, 1'b0, 2'd0, 16'd0, 4'h0, 4'h0};
        vec[18] = '{4'h2, 1'b0, 2'd0, 16'd0, 4'h0, 4'h0};
        vec[19] = '{4'h2, 1'b0, 2'd0, 16'd0, 4'h2, 4'h2};
        vec[20] = '{4'h2, 1'b0, 2'd0, 16'd0, 4'h2, 4'h2};
        vec[21] = '{4'h2, 1'b0, 2'd0, 16'd0, 4'h2, 4'h2};

        step();
        step();
        check("rst_hold_tick", 32'(tick), 32'h0);
        check("rst_hold_wave", 32'(wave), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            if (i == 4) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("async_rst_tick", 32'(tick), 32'h0);
                check("async_rst_wave", 32'(wave), 32'h0);
                rst_n = 1'b1;
            end
            en     = vec[i].en;
            wr_en  = vec[i].wr_en;
            wr_ch  = vec[i].wr_ch;
            wr_div = vec[i].wr_div;
            step();
            check($sformatf("vec%0d_tick", i), 32'(tick), 32'(vec[i].exp_tick));
            check($sformatf("vec%0d_wave", i), 32'(wave), 32'(vec[i].exp_wave));
        end
        wr_en = 1'b0;

        // mid-period reload on ch0: D=8, write 3 at cnt=3, then 5 on a wrap edge
        w_reload = 27'b111000011011011011100111001;
        do_reset();
        write(2'd0, 16'd8);
        en = 4'b0001;
        for (int i = 0; i < 27; i++) begin
            if (i == 3) begin
                wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd3;
            end else if (i == 16) begin
                wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd5;
            end else begin
                wr_en = 1'b0;
            end
            step();
            et = (i == 7 || i == 10 || i == 13 || i == 16 || i == 21 || i == 26) ? 4'b0001 : 4'b0000;
            ew = w_reload[i] ? 4'b0001 : 4'b0000;
            check($sformatf("reload%0d_tick", i), 32'(tick), 32'(et));
            check($sformatf("reload%0d_wave", i), 32'(wave), 32'(ew));
        end
        wr_en = 1'b0;

        // sync_clr alignment of ch0 and ch2 at D=6
        do_reset();
        write(2'd0, 16'd6);
        write(2'd2, 16'd6);
        en = 4'b0001;
        step();
        step();
        en = 4'b0101;
        step();
        step();
        step();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        check("clr_tick", 32'(tick), 32'h0);
        check("clr_wave", 32'(wave), 32'h0);
        for (int i = 0; i < 18; i++) begin
            step();
            et = ((i % 6) == 5) ? 4'b0101 : 4'b0000;
            ew = ((i % 6) == 0 || (i % 6) == 1 || (i % 6) == 5) ? 4'b0101 : 4'b0000;
            check($sformatf("align%0d_tick", i), 32'(tick), 32'(et));
            check($sformatf("align%0d_wave", i), 32'(wave), 32'(ew));
        end

        // disable on the wrap edge of ch3 (D=4), then re-enable
        w_dis = 8'b10011001;
        do_reset();
        write(2'd3, 16'd4);
        en = 4'b1000;
        step();
        step();
        step();
        check("pre_dis_wave", 32'(wave), 32'h0);
        en = 4'b0000;
        step();
        check("dis_wrap_tick", 32'(tick), 32'h0);
        check("dis_wrap_wave", 32'(wave), 32'h0);
        step();
        check("dis_idle_tick", 32'(tick), 32'h0);
        en = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            step();
            et = (i == 3 || i == 7) ? 4'b1000 : 4'b0000;
            ew = w_dis[i] ? 4'b1000 : 4'b0000;
            check($sformatf("reen%0d_tick", i), 32'(tick), 32'(et));
            check($sformatf("reen%0d_wave", i), 32'(wave), 32'(ew));
        end

        // NUM_CH=3 build: a write to channel index 3 must not change anything
        do_reset();
        en3     = 3'b111;
        wr_en3  = 1'b1;
        wr_ch3  = 2'd3;
        wr_div3 = 16'd7;
        for (int i = 0; i < 8; i++) begin
            step();
            et = (i % 2 == 1) ? 4'b0111 : 4'b0000;
            check($sformatf("oob%0d_tick", i), 32'(tick3), 32'(et));
            check($sformatf("oob%0d_wave", i), 32'(wave3), 32'(et));
        end
        wr_en3 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
- Multi-channel programmable clock-enable generator. It is the successor to the fixed single-output divider.
- Each of NUM_CH channels produces a one-cycle tick strobe and a ~50% square wave, both derived from clk_in. Divisors are runtime-programmable.
- Outputs are enables/levels in the clk_in domain, not new clocks. No BUFG. Consumers gate logic with tick.
- Feeds the game tick, sound and display-refresh logic.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- DIV_WIDTH, 16, width of each divisor and counter.
- DEFAULT_DIV, 2, divisor loaded into every channel at reset. Must be 1..2^DIV_WIDTH-1.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  NUM_CH  per-channel run enable (level).
- sync_clr  input  1  synchronous phase-align pulse; restarts all channels together.
- wr_en  input  1  divisor write strobe.
- wr_ch  input  max(1,$clog2(NUM_CH))  channel index for the write. Values >= NUM_CH are ignored.
- wr_div  input  DIV_WIDTH  new divisor D. A value of 0 is treated as 1.
- tick  output  NUM_CH  one-cycle strobe per period (registered).
- wave  output  NUM_CH  square wave per channel (registered).

Behaviour:
- Per-channel state: shadow divisor S, active divisor A, counter cnt (DIV_WIDTH bits), tick_q, wave_q.
- Reset (rst_n low, asynchronous):
  - S = A = DEFAULT_DIV, cnt = 0.
  - tick = 0, wave = 0 on all channels.
  - Release is sampled at the next clk_in edge.
- Write: on an edge with wr_en=1 and wr_ch < NUM_CH, S[wr_ch] <= (wr_div==0 ? 1 : wr_div).
- Reload timing: A loads from S only at a period boundary, so a new divisor never truncates the current period. Boundaries are:
  - a wrap;
  - any edge with en low;
  - sync_clr.
- Write forwarding: if a write to channel c and a boundary on c occur at the same edge, A takes the newly written value.
- Running (en[c]=1, sync_clr=0):
  - If cnt == A-1: cnt <= 0 (wrap) and A <= S.
  - Otherwise cnt <= cnt+1.
  - tick_q <= (cnt == A-1). The tick is high for exactly one cycle per period.
- First tick: enable sampled high at edge k with cnt=0. The first tick is high in the cycle after edge k+A-1. Subsequent ticks follow every A cycles.
- D=1: tick is high on every cycle while enabled.
- wave_q <= (cnt_next < ceil(A_next/2)).
  - Period starts in the cycle after a tick. High for ceil(D/2) cycles, low for floor(D/2).
  - D=1 gives wave constantly high while enabled.
- Disabled (en[c]=0): cnt <= 0, tick_q <= 0, wave_q <= 0, A <= S. Re-enabling restarts phase from zero.
- sync_clr=1 (priority over run, below reset): on all channels at that edge:
  - cnt <= 0, tick_q <= 0, wave_q <= 0, A <= S (with write forwarding).
  - Enabled channels resume counting from the next edge, so all channels with equal D are phase-aligned.
- Simultaneous en falling edge and wrap: the disable wins. No tick is produced.
- No combinational path from any input to tick or wave.
- Counter never exceeds A-1. Wrap compare is >= A-1 so a glitched state self-recovers.

Decomposition:
- Package clkdiv_pkg:
  - DIV_WIDTH_DEFAULT constant;
  - div_t typedef (logic [DIV_WIDTH-1:0]);
  - function sanitize_div (maps 0 to 1);
  - function half_ceil(D).
- Sub-module clkdiv_chan: one channel. Holds S, A, cnt, tick_q and wave_q. Inputs are en, clr, wr (pre-decoded) and wr_div.
- clkdiv_multi generates NUM_CH instances and the wr_ch decode.

Test Plan:
- Reset defaults: hold rst_n=0, assert en=all ones, release. Every channel ticks once per 2 cycles; wave pattern is 1,0,1,0. Assert rst_n low mid-run: tick and wave drop to 0 immediately, without waiting for a clock.
- Divisor 5 on ch1:
  - Write wr_ch=1, wr_div=5 while ch1 is disabled, then enable at edge k.
  - First tick follows edge k+4; tick period is 5 cycles.
  - wave is high for 3 cycles and low for 2.
  - Writing wr_div=0 yields a tick on every cycle.
- Mid-period reload:
  - ch0 is running with D=8; at cnt=3, write D=3.
  - The current period still completes at 8 cycles, then the period becomes 3.
  - Repeat with the write on the exact wrap edge: the new value applies immediately (forwarding).
- sync_clr alignment:
  - ch0 and ch2 at D=6 with different phases; pulse sync_clr.
  - tick and wave are 0 the next cycle; afterwards ch0 and ch2 ticks coincide every 6 cycles.
- Disable boundary:
  - Drop en[3] on the same edge that cnt hits A-1: no tick is produced and wave=0.
  - Re-enable: the first tick comes A edges later.
  - A write with wr_ch >= NUM_CH (NUM_CH=3 build) changes no channel.
